// File: rtl/du_loader.sv
// Debug-unit firmware loader: pulls one length/data/checksum/EOT frame from the UART Rx FIFO into IMEM
// and answers ACK/NAK on the Tx FIFO. Optional inter-byte timeout when LOADER_TIMEOUT_EN is defined.
//
// state      | meaning
// IDLE       | waiting for i_start
// LEN_LO     | pop length low byte
// LEN_HI     | pop length high byte
// CHK_LEN    | reject N==0 or N>capacity
// DATA       | pop data bytes, assemble words, write IMEM
// CSUM       | pop checksum byte, flag mismatch
// EOT_CHK    | pop EOT byte, decide ACK/NAK
// SEND_ACK   | queue 0x05 once Tx FIFO has room
// SEND_NAK   | queue 0x15, then restart at LEN_LO
// DONE       | pulse o_done
// WAIT_REL   | hold until master drops i_start
module du_loader #(
    parameter int NB_INSTRUCTION = 32,
    parameter int NB_UART_DATA   = 8,
    parameter int NB_IMEM_ADDR   = 10
`ifdef LOADER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 100_000_000
`endif
) (
    input  logic                      clk,
    input  logic                      i_rst_n,
    input  logic                      i_start,
    input  logic [NB_UART_DATA-1:0]   i_rx_data,
    input  logic                      i_rx_done,
    input  logic                      i_tx_full,
    output logic                      o_rd,
    output logic                      o_wr,
    output logic [NB_UART_DATA-1:0]   o_wdata,
    output logic                      o_tx_start,
    output logic                      o_imem_we,
    output logic [NB_IMEM_ADDR-1:0]   o_imem_addr,
    output logic [NB_INSTRUCTION-1:0] o_imem_data,
    output logic                      o_done
);

    localparam int CAP     = 2 ** (NB_IMEM_ADDR - 2);
    localparam int NB_WIDX = NB_IMEM_ADDR - 1;
    localparam int BPW     = NB_INSTRUCTION / NB_UART_DATA;
    localparam int NB_BIDX = $clog2(BPW);
    localparam int NB_ASM  = NB_INSTRUCTION - NB_UART_DATA;

    localparam logic [NB_UART_DATA-1:0] EOT_B = NB_UART_DATA'(8'h04);
    localparam logic [NB_UART_DATA-1:0] ACK_B = NB_UART_DATA'(8'h05);
    localparam logic [NB_UART_DATA-1:0] NAK_B = NB_UART_DATA'(8'h15);

    typedef enum logic [3:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_CHK_LEN, S_DATA, S_CSUM,
        S_EOT_CHK, S_SEND_ACK, S_SEND_NAK, S_DONE, S_WAIT_REL
    } state_t;

    state_t state_q, state_d;

    logic [15:0]               len_q;
    logic [NB_WIDX-1:0]        widx_q;
    logic [NB_BIDX-1:0]        bidx_q;
    logic [NB_UART_DATA-1:0]   csum_q;
    logic                      err_q;
    logic [NB_ASM-1:0]         asm_q;
    logic                      we_q;
    logic [NB_IMEM_ADDR-1:0]   addr_q;
    logic [NB_INSTRUCTION-1:0] data_q;

    logic rx_state, pop, last_byte, last_word, len_bad, clr_ctx, timeout;

    assign rx_state  = state_q inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_EOT_CHK};
    assign pop       = i_start && i_rx_done && rx_state;
    assign last_byte = (bidx_q == NB_BIDX'(BPW - 1));
    assign last_word = ((16'(widx_q) + 16'd1) == len_q);
    assign len_bad   = (len_q == 16'd0) || (len_q > 16'(CAP));
    assign clr_ctx   = (state_q == S_IDLE && i_start) || (state_q == S_SEND_NAK && !i_tx_full);

`ifdef LOADER_TIMEOUT_EN
    // Down-counter reloaded on every pop; reaching zero in a timed state means the host stalled.
    logic [31:0] tmo_q;
    logic        timed;
    assign timed   = state_q inside {S_LEN_HI, S_DATA, S_CSUM, S_EOT_CHK};
    assign timeout = timed && !pop && (tmo_q == 32'd0);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tmo_q <= '0;
        end else if (pop || (state_d == S_LEN_LO && state_q != S_LEN_LO)) begin
            tmo_q <= 32'(TIMEOUT_CYCLES - 1);
        end else if (timed && tmo_q != 32'd0) begin
            tmo_q <= tmo_q - 32'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (i_start) state_d = S_LEN_LO;
            S_LEN_LO:   if (pop) state_d = S_LEN_HI;
            S_LEN_HI:   if (pop) state_d = S_CHK_LEN;
            S_CHK_LEN:  state_d = len_bad ? S_SEND_NAK : S_DATA;
            S_DATA:     if (pop && last_byte && last_word) state_d = S_CSUM;
            S_CSUM:     if (pop) state_d = S_EOT_CHK;
            S_EOT_CHK:  if (pop) state_d = (i_rx_data != EOT_B || err_q) ? S_SEND_NAK : S_SEND_ACK;
            S_SEND_ACK: if (!i_tx_full) state_d = S_DONE;
            S_SEND_NAK: if (!i_tx_full) state_d = S_LEN_LO;
            S_DONE:     state_d = S_WAIT_REL;
            S_WAIT_REL: if (!i_start) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
        if (timeout) state_d = S_SEND_NAK;
        if (!i_start && state_q != S_WAIT_REL) state_d = S_IDLE;
    end

    always_comb begin
        o_rd        = pop;
        o_wr        = i_start && !i_tx_full && (state_q == S_SEND_ACK || state_q == S_SEND_NAK);
        o_tx_start  = o_wr;
        o_wdata     = '0;
        if (o_wr) o_wdata = (state_q == S_SEND_NAK) ? NAK_B : ACK_B;
        o_done      = i_start && (state_q == S_DONE);
        o_imem_we   = we_q;
        o_imem_addr = addr_q;
        o_imem_data = data_q;
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            len_q  <= '0;
            widx_q <= '0;
            bidx_q <= '0;
            csum_q <= '0;
            err_q  <= 1'b0;
            asm_q  <= '0;
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            we_q <= 1'b0;
            if (clr_ctx) begin
                widx_q <= '0;
                bidx_q <= '0;
                csum_q <= '0;
                err_q  <= 1'b0;
            end
            if (pop) begin
                case (state_q)
                    S_LEN_LO: len_q[7:0]  <= 8'(i_rx_data);
                    S_LEN_HI: len_q[15:8] <= 8'(i_rx_data);
                    S_DATA: begin
                        csum_q <= csum_q ^ i_rx_data;
                        if (last_byte) begin
                            we_q   <= 1'b1;
                            addr_q <= {widx_q[NB_IMEM_ADDR-3:0], 2'b00};
                            data_q <= {i_rx_data, asm_q};
                            bidx_q <= '0;
                            if (widx_q != NB_WIDX'(CAP)) widx_q <= widx_q + 1'b1;
                        end else begin
                            asm_q  <= {i_rx_data, asm_q[NB_ASM-1:NB_UART_DATA]};
                            bidx_q <= bidx_q + 1'b1;
                        end
                    end
                    S_CSUM: if (i_rx_data != csum_q) err_q <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_du_loader.sv
// Self-checking bench for du_loader: table-driven frames, hand sequences for retransmit/abort/reset,
// and randomized frames checked against a frame-level reference model.
module tb_du_loader;

    logic        clk;
    logic        i_rst_n;
    logic        i_start;
    logic [7:0]  i_rx_data;
    logic        i_rx_done;
    logic        i_tx_full;
    logic        o_rd;
    logic        o_wr;
    logic [7:0]  o_wdata;
    logic        o_tx_start;
    logic        o_imem_we;
    logic [9:0]  o_imem_addr;
    logic [31:0] o_imem_data;
    logic        o_done;

    du_loader dut (
        .clk        (clk),
        .i_rst_n    (i_rst_n),
        .i_start    (i_start),
        .i_rx_data  (i_rx_data),
        .i_rx_done  (i_rx_done),
        .i_tx_full  (i_tx_full),
        .o_rd       (o_rd),
        .o_wr       (o_wr),
        .o_wdata    (o_wdata),
        .o_tx_start (o_tx_start),
        .o_imem_we  (o_imem_we),
        .o_imem_addr(o_imem_addr),
        .o_imem_data(o_imem_data),
        .o_done     (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         len;
        int         nbody;
        logic [7:0] cx;
        logic [7:0] eot;
        int         gap;
        int         full;
        logic [7:0] etx;
        int         edone;
        int         enw;
    } vec_t;

    vec_t tbl [9];

    logic [7:0]  rxq [$];
    logic [7:0]  fr [$];
    int          popc [$];
    logic [9:0]  wa [$];
    logic [31:0] wd [$];
    int          wc [$];
    logic [7:0]  txb [$];
    int          txc [$];
    int          donec [$];
    logic [9:0]  ew_a [$];
    logic [31:0] ew_d [$];
    logic [7:0]  m_tx;
    int          m_done;
    int          m_cons;
    int          cyc, viol, gap, full_left;
    int          pass_cnt, total_cnt;

    task automatic chk(input string nm, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    endtask

    function automatic logic [31:0] word_for(input int i);
        case (i)
            0:       return 32'h00500093;
            1:       return 32'h1A1A1A1A;
            default: return {8'(i * 7 + 3), 8'(i), 8'hA5, 8'(i ^ 8'h3C)};
        endcase
    endfunction

    task automatic make_frame(input int len, input int nbody, input logic [7:0] cx,
                              input logic [7:0] eot, input bit rnd);
        logic [7:0]  cs;
        logic [31:0] w;
        logic [15:0] l16;
        l16 = 16'(len);
        fr.delete();
        fr.push_back(l16[7:0]);
        fr.push_back(l16[15:8]);
        cs = 8'h00;
        for (int i = 0; i < nbody; i++) begin
            if (rnd) w = ($urandom_range(0, 3) == 0) ? 32'h1A1A1A1A : $urandom;
            else     w = word_for(i);
            for (int b = 0; b < 4; b++) begin
                fr.push_back(w[8*b +: 8]);
                cs ^= w[8*b +: 8];
            end
        end
        fr.push_back(cs ^ cx);
        fr.push_back(eot);
        fr.push_back(8'h5A);
    endtask

    // Frame-level expectation: which words land where, what reply byte, how many bytes consumed.
    task automatic model();
        int         n;
        logic [7:0] cs;
        bit         ok;
        n = int'({fr[1], fr[0]});
        ew_a.delete();
        ew_d.delete();
        if (n == 0 || n > 256) begin
            m_tx = 8'h15; m_done = 0; m_cons = 2;
        end else begin
            cs = 8'h00;
            for (int i = 0; i < 4 * n; i++) cs ^= fr[2 + i];
            for (int i = 0; i < n; i++) begin
                ew_a.push_back(10'(i * 4));
                ew_d.push_back({fr[2+4*i+3], fr[2+4*i+2], fr[2+4*i+1], fr[2+4*i]});
            end
            ok     = (fr[2 + 4*n] == cs) && (fr[3 + 4*n] == 8'h04);
            m_tx   = ok ? 8'h05 : 8'h15;
            m_done = ok ? 1 : 0;
            m_cons = 4 + 4 * n;
        end
    endtask

    task automatic push_frame();
        foreach (fr[i]) rxq.push_back(fr[i]);
    endtask

    task automatic clear_logs();
        rxq.delete(); popc.delete(); wa.delete(); wd.delete(); wc.delete();
        txb.delete(); txc.delete(); donec.delete();
        viol = 0;
        full_left = 0;
    endtask

    // One clock: drive inputs on the falling edge, sample settled outputs just before the rising edge.
    task automatic step();
        bit avail;
        @(negedge clk);
        cyc++;
        case (gap)
            0:       avail = 1'b1;
            1:       avail = cyc[0];
            default: avail = 1'($urandom_range(0, 1));
        endcase
        i_rx_done = (txc.size() == 0) && (rxq.size() > 0) && avail;
        i_rx_data = (rxq.size() > 0) ? rxq[0] : 8'h00;
        if (txc.size() == 0 && rxq.size() == 1 && full_left > 0) begin
            i_tx_full = 1'b1;
            full_left--;
        end else begin
            i_tx_full = 1'b0;
        end
        #4;
        if (o_rd && !i_rx_done) viol++;
        if (o_wr && i_tx_full) viol++;
        if (o_wr != o_tx_start) viol++;
        if (o_imem_we && o_imem_addr[1:0] != 2'b00) viol++;
        if (o_rd && rxq.size() > 0) begin
            void'(rxq.pop_front());
            popc.push_back(cyc);
        end
        if (o_imem_we) begin
            wa.push_back(o_imem_addr);
            wd.push_back(o_imem_data);
            wc.push_back(cyc);
        end
        if (o_wr) begin
            txb.push_back(o_wdata);
            txc.push_back(cyc);
        end
        if (o_done) donec.push_back(cyc);
    endtask

    task automatic run(input int budget);
        for (int k = 0; k < budget; k++) begin
            step();
            if (txc.size() > 0 && cyc >= txc[0] + 3) break;
        end
    endtask

    task automatic evaluate(input string nm, input int full, input logic [7:0] etx,
                            input int edone, input int enw);
        int mism;
        int lat;
        int idx;
        model();
        chk({nm, " tx_count"}, txc.size(), 1);
        if (txc.size() > 0) begin
            chk({nm, " tx_byte"}, txb[0], etx);
            if (popc.size() >= m_cons)
                chk({nm, " tx_time"}, txc[0] - popc[m_cons-1], (m_cons == 2) ? 2 : 1 + full);
        end
        chk({nm, " done_count"}, donec.size(), edone);
        if (donec.size() > 0 && txc.size() > 0)
            chk({nm, " done_time"}, donec[0], txc[0] + 1);
        chk({nm, " n_writes"}, wa.size(), enw);
        mism = 0;
        for (int j = 0; j < wa.size(); j++)
            if (j >= ew_a.size() || wa[j] != ew_a[j] || wd[j] != ew_d[j]) mism++;
        chk({nm, " write_data"}, mism, 0);
        lat = 0;
        for (int j = 0; j < wa.size(); j++) begin
            idx = 2 + 4 * j + 3;
            if (idx >= popc.size() || wc[j] != popc[idx] + 1) lat++;
        end
        chk({nm, " write_latency"}, lat, 0);
        chk({nm, " leftover"}, rxq.size(), fr.size() - m_cons);
        chk({nm, " protocol"}, viol, 0);
    endtask

    initial begin
        int rem;
        int len, nbody, full;
        logic [7:0] cx, eot;

        pass_cnt = 0; total_cnt = 0; cyc = 0; gap = 0;
        clear_logs();
        i_rst_n = 1'b0; i_start = 1'b0; i_rx_data = 8'h00; i_rx_done = 1'b0; i_tx_full = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", {o_rd, o_wr, o_tx_start, o_imem_we, o_done, o_wdata, o_imem_addr, o_imem_data}, 0);
        @(negedge clk);
        i_rst_n = 1'b1;

        tbl[0] = '{2,   2,   8'h00, 8'h04, 0, 0,  8'h05, 1, 2};
        tbl[1] = '{2,   2,   8'h01, 8'h04, 0, 0,  8'h15, 0, 2};
        tbl[2] = '{2,   2,   8'h00, 8'h03, 0, 0,  8'h15, 0, 2};
        tbl[3] = '{0,   0,   8'h00, 8'h04, 0, 0,  8'h15, 0, 0};
        tbl[4] = '{257, 1,   8'h00, 8'h04, 0, 0,  8'h15, 0, 0};
        tbl[5] = '{256, 256, 8'h00, 8'h04, 0, 0,  8'h05, 1, 256};
        tbl[6] = '{3,   3,   8'h00, 8'h04, 1, 0,  8'h05, 1, 3};
        tbl[7] = '{2,   2,   8'h00, 8'h04, 0, 10, 8'h05, 1, 2};
        tbl[8] = '{1,   1,   8'h00, 8'h04, 2, 3,  8'h05, 1, 1};

        for (int r = 0; r < 9; r++) begin
            i_start = 1'b0;
            step(); step();
            clear_logs();
            gap = tbl[r].gap;
            full_left = tbl[r].full;
            i_start = 1'b1;
            make_frame(tbl[r].len, tbl[r].nbody, tbl[r].cx, tbl[r].eot, 1'b0);
            push_frame();
            run(3000);
            evaluate($sformatf("vec%0d", r), tbl[r].full, tbl[r].etx, tbl[r].edone, tbl[r].enw);
            if (r == 0 && wd.size() >= 2) begin
                chk("vec0 word0", wd[0], 32'h00500093);
                chk("vec0 word1", wd[1], 32'h1A1A1A1A);
                chk("vec0 addr1", wa[1], 10'h004);
            end
            if (r == 5 && wa.size() > 0) chk("vec5 last_addr", wa[wa.size()-1], 10'h3FC);
        end

        // Bad checksum, then retransmission from LEN_LO without releasing i_start.
        i_start = 1'b0; gap = 0;
        step(); step();
        clear_logs();
        i_start = 1'b1;
        make_frame(2, 2, 8'h01, 8'h04, 1'b0);
        push_frame();
        run(300);
        evaluate("resend_bad", 0, 8'h15, 0, 2);
        clear_logs();
        make_frame(2, 2, 8'h00, 8'h04, 1'b0);
        push_frame();
        run(300);
        evaluate("resend_good", 0, 8'h05, 1, 2);

        // Abort after six data bytes.
        i_start = 1'b0;
        step(); step();
        clear_logs();
        i_start = 1'b1;
        make_frame(2, 2, 8'h00, 8'h04, 1'b0);
        for (int i = 0; i < 8; i++) rxq.push_back(fr[i]);
        for (int k = 0; k < 50 && popc.size() < 8; k++) step();
        chk("abort reached", popc.size(), 8);
        step(); step();
        i_start = 1'b0;
        repeat (5) step();
        for (int i = 8; i < fr.size(); i++) rxq.push_back(fr[i]);
        rem = rxq.size();
        repeat (5) step();
        chk("abort no_pop_idle", rxq.size(), rem);
        chk("abort tx_count", txc.size(), 0);
        chk("abort done_count", donec.size(), 0);
        chk("abort n_writes", wa.size(), 1);
        if (wd.size() > 0) chk("abort word0", wd[0], 32'h00500093);
        clear_logs();
        i_start = 1'b1;
        make_frame(2, 2, 8'h00, 8'h04, 1'b0);
        push_frame();
        run(300);
        evaluate("after_abort", 0, 8'h05, 1, 2);

        // Asynchronous reset in the middle of DATA.
        i_start = 1'b0;
        step(); step();
        clear_logs();
        i_start = 1'b1;
        make_frame(2, 2, 8'h00, 8'h04, 1'b0);
        push_frame();
        for (int k = 0; k < 50 && popc.size() < 7; k++) step();
        chk("reset reached", popc.size(), 7);
        @(negedge clk);
        i_rx_done = 1'b1;
        i_rx_data = rxq[0];
        #2 i_rst_n = 1'b0;
        #1;
        chk("reset mid_data", {o_rd, o_wr, o_tx_start, o_imem_we, o_done, o_wdata, o_imem_addr, o_imem_data}, 0);
        @(negedge clk);
        i_rst_n = 1'b1;
        clear_logs();
        make_frame(2, 2, 8'h00, 8'h04, 1'b0);
        push_frame();
        run(300);
        evaluate("after_reset", 0, 8'h05, 1, 2);

        // Randomized frames against the reference model.
        for (int r = 0; r < 12; r++) begin
            i_start = 1'b0;
            step(); step();
            clear_logs();
            case ($urandom_range(0, 9))
                0:       begin len = 0;   nbody = 0; end
                1:       begin len = 300; nbody = 1; end
                default: begin len = $urandom_range(1, 8); nbody = len; end
            endcase
            cx   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            eot  = ($urandom_range(0, 7) == 0) ? 8'h03 : 8'h04;
            gap  = $urandom_range(0, 2);
            full = $urandom_range(0, 5);
            full_left = full;
            i_start = 1'b1;
            make_frame(len, nbody, cx, eot, 1'b1);
            push_frame();
            run(500);
            model();
            evaluate($sformatf("rand%0d", r), full, m_tx, m_done, ew_a.size());
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/du_loader.md
Name: du_loader

Overview:
- Firmware loader for the debug unit, the responder to the master controller's load request.
- While i_start is held, it consumes one firmware frame from the UART Rx FIFO, assembles little-endian 32-bit words and writes them into IMEM.
- It then verifies the frame trailer, answers ACK or NAK through the UART Tx FIFO, and pulses o_done after a successful load.
- It sits between the UART FIFOs and the IMEM write port and is active only while the master is in its firmware-receive phase.

Parameters:
NB_INSTRUCTION, 32, IMEM word width
NB_UART_DATA, 8, UART FIFO data width
NB_IMEM_ADDR, 10, IMEM byte-address width; capacity = 2**(NB_IMEM_ADDR-2) words (256)
TIMEOUT_CYCLES, 100_000_000, inter-byte timeout (Optional Feature only)

Ports:
clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  level; load requested, held by master for whole load
i_rx_data  in  8  UART Rx FIFO head byte, valid when i_rx_done=1
i_rx_done  in  1  Rx FIFO non-empty
i_tx_full  in  1  Tx FIFO full
o_rd  out  1  Rx FIFO pop strobe
o_wr  out  1  Tx FIFO write strobe
o_wdata  out  8  Tx FIFO write data
o_tx_start  out  1  Tx start pulse, coincident with o_wr
o_imem_we  out  1  IMEM write enable
o_imem_addr  out  NB_IMEM_ADDR  IMEM byte address, word aligned
o_imem_data  out  NB_INSTRUCTION  IMEM write data
o_done  out  1  one-cycle pulse: load completed and ACK queued

Behaviour:
- Frame, after the SOT already consumed by the master: LEN_LO, LEN_HI (word count N, little-endian), N×4 data bytes (LSB first), CSUM (XOR of all data bytes only), EOT=0x04.
- Byte consumption: a byte is taken in a cycle where i_rx_done=1 and the FSM is in a receive state. That cycle asserts o_rd=1 and samples i_rx_data. At most one pop per cycle.
- Reset: async; state=IDLE; all counters, the checksum and all outputs are 0.
- All strobe outputs (o_rd, o_wr, o_tx_start, o_imem_we, o_done) are single-cycle and default to 0.
- States:
  - IDLE: wait for i_start=1, then clear the word index, byte index and checksum, and go to LEN_LO.
  - LEN_LO / LEN_HI: pop one byte each into a 16-bit length register.
  - CHK_LEN: one cycle. If N==0 or N>capacity, go to SEND_NAK. Otherwise go to DATA.
  - DATA: pop bytes into the shift assembler and XOR each into the checksum.
    - On the 4th byte, the next cycle drives o_imem_we=1, o_imem_addr=word_idx×4 and o_imem_data=the assembled word. word_idx increments.
    - Write latency: 1 cycle after the last byte pop.
    - After word N-1 is written, go to CSUM.
  - CSUM: pop one byte. A mismatch sets an error flag.
  - EOT_CHK: pop one byte. If byte≠0x04 or the error flag is set, go to SEND_NAK. Otherwise go to SEND_ACK.
  - SEND_ACK: wait while i_tx_full=1, then o_wr=o_tx_start=1 with o_wdata=0x05 for one cycle, then go to DONE.
  - SEND_NAK: same handshake with o_wdata=0x15. Then go to LEN_LO with counters and checksum cleared; the host retransmits from LEN_LO.
  - DONE: o_done=1 for one cycle, then go to WAIT_REL.
  - WAIT_REL: wait for i_start=0, then go to IDLE. This prevents a re-load while the master is still in its load phase.
- i_start falling in any state other than WAIT_REL aborts to IDLE. There is no ACK, NAK or o_done in that case. IMEM words already written are left as is.
- Bytes beyond EOT are not consumed.
- The word index saturates at capacity; no address wrap is possible because of the length check.
- The data value 0x1A1A1A1A (halt marker) is stored like any other word.

Optional Feature:
- LOADER_TIMEOUT_EN defined:
  - A 32-bit counter runs in LEN_HI, DATA, CSUM and EOT_CHK.
  - It clears on every pop and on entry to LEN_LO.
  - Reaching TIMEOUT_CYCLES-1 forces SEND_NAK.
  - LEN_LO waits indefinitely.
- Not defined: the counter is absent and every receive state waits indefinitely.

Test Plan:
- Good frame: bytes 02 00 | 93 00 50 00 | 1A 1A 1A 1A | C3 | 04 -> IMEM writes (addr 0x000, 0x00500093) and (addr 0x004, 0x1A1A1A1A); Tx byte 0x05; o_done pulses once, one cycle after the Tx write.
- Bad checksum: same frame with CSUM=0xC2 -> both IMEM writes still occur; Tx byte 0x15; no o_done. Resending the good frame -> Tx byte 0x05 and o_done.
- Length limits: LEN=00 00 -> NAK immediately after LEN_HI with no IMEM write. LEN=01 01 (257) -> NAK. LEN=00 01 (256) -> 256 writes with the last at addr 0x3FC, then ACK.
- Tx back-pressure: i_tx_full=1 for 10 cycles at SEND_ACK -> o_wr held 0 for those cycles, then a single 0x05 write. Rx gaps: i_rx_done toggling every other cycle -> identical IMEM contents.
- Abort and reset: i_start dropped after 6 data bytes -> IDLE with no Tx write. Separately, i_rst_n=0 mid-DATA -> all outputs 0 asynchronously, and a new frame after release loads correctly.
- With LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=50: a stall of 50 cycles after LEN_LO -> NAK written on the 50th cycle of the stall.
